// File: rtl/fetch_pc_gen.sv
// 3-wide fetch-PC generator: drives lane PCs to the branch predictor, picks the next
// fetch PC from the same-cycle prediction, and hands groups to the fetch queue.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC      = 32'h1c000000,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [2:0][31:0] pc,
    input  logic [2:0][31:0] pc_predict,
    input  logic [2:0]       predict_valid,
    input  logic [2:0]       predict,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [31:0]      fetch_pc,
    output logic [2:0]       fetch_lane_valid,
    output logic [2:0]       fetch_taken,
    output logic [31:0]      fetch_target,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StBubble = 2'd1,
        StHold   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [2:0]  lane_taken;
    logic [2:0]  sel_lane_valid;
    logic [2:0]  sel_taken;
    logic [31:0] sel_target;

    assign lane_taken = predict_valid & predict;

    always_comb begin
        pc[0] = fpc_q;
        pc[1] = fpc_q + 32'd4;
        pc[2] = fpc_q + 32'd8;
    end

    // First taken lane ends the group; later lanes are cut.
    always_comb begin
        sel_lane_valid = 3'b111;
        sel_taken      = 3'b000;
        sel_target     = fpc_q + 32'd12;
        casez (lane_taken)
            3'b??1: begin
                sel_lane_valid = 3'b001;
                sel_taken      = 3'b001;
                sel_target     = pc_predict[0] & ~32'h3;
            end
            3'b?10: begin
                sel_lane_valid = 3'b011;
                sel_taken      = 3'b010;
                sel_target     = pc_predict[1] & ~32'h3;
            end
            3'b100: begin
                sel_lane_valid = 3'b111;
                sel_taken      = 3'b100;
                sel_target     = pc_predict[2] & ~32'h3;
            end
            default: ;
        endcase
    end

    always_comb begin
        fetch_pc         = fpc_q;
        state            = state_q;
        fetch_valid      = (state_q != StBubble);
        fetch_lane_valid = sel_lane_valid;
        fetch_taken      = sel_taken;
        fetch_target     = sel_target;
        if (rst) begin
            fetch_valid      = 1'b0;
            fetch_lane_valid = 3'b000;
            fetch_taken      = 3'b000;
            fetch_target     = RESET_PC + 32'd12;
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        if (redirect_en) begin
            // A coincident handshake still counts as accepted; the redirect wins the PC.
            fpc_d   = redirect_pc & ~32'h3;
            state_d = StBubble;
            cnt_d   = 2'(FLUSH_BUBBLES - 1);
        end else begin
            unique case (state_q)
                StRun: begin
                    if (fetch_ready) fpc_d = sel_target;
                    else             state_d = StHold;
                end
                StHold: begin
                    if (fetch_ready) begin
                        fpc_d   = sel_target;
                        state_d = StRun;
                    end
                end
                StBubble: begin
                    if (cnt_q == 2'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fpc_q   <= RESET_PC;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized bench for fetch_pc_gen against a cycle-level reference model of the fetch
// PC sequence, plus directed scenarios with fixed expected values.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC      = 32'h1c000000;
    localparam int unsigned FLUSH_BUBBLES = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][31:0] pc;
    logic [2:0][31:0] pc_predict;
    logic [2:0]       predict_valid;
    logic [2:0]       predict;
    logic             redirect_en;
    logic [31:0]      redirect_pc;
    logic             fetch_ready;
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic [2:0]       fetch_lane_valid;
    logic [2:0]       fetch_taken;
    logic [31:0]      fetch_target;
    logic [1:0]       state;

    fetch_pc_gen #(
        .RESET_PC      (RESET_PC),
        .FLUSH_BUBBLES (FLUSH_BUBBLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .pc_predict       (pc_predict),
        .predict_valid    (predict_valid),
        .predict          (predict),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_lane_valid (fetch_lane_valid),
        .fetch_taken      (fetch_taken),
        .fetch_target     (fetch_target),
        .state            (state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current fetch PC, remaining bubble cycles, and whether a group is stalled.
    logic [31:0] m_fpc = RESET_PC;
    int          m_bubbles = 0;
    bit          m_stalled = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_taken();
        for (int i = 0; i < 3; i++)
            if (predict_valid[i] && predict[i]) return i;
        return 3;
    endfunction

    function automatic logic [31:0] m_target();
        int k = first_taken();
        if (k == 3) return m_fpc + 32'd12;
        return {pc_predict[k][31:2], 2'b00};
    endfunction

    function automatic logic [2:0] m_lane_valid();
        int k = first_taken();
        if (k == 3) return 3'b111;
        return 3'((1 << (k + 1)) - 1);
    endfunction

    function automatic logic [2:0] m_taken();
        int k = first_taken();
        if (k == 3) return 3'b000;
        return 3'(1 << k);
    endfunction

    // Compare every output against the model; called mid-cycle on the falling edge.
    task automatic sample();
        @(negedge clk);
        if (rst) begin
            check_val("rst_valid", 32'(fetch_valid), 32'd0);
            check_val("rst_lane_valid", 32'(fetch_lane_valid), 32'd0);
            check_val("rst_taken", 32'(fetch_taken), 32'd0);
            check_val("rst_target", fetch_target, RESET_PC + 32'd12);
        end else begin
            check_val("valid", 32'(fetch_valid), 32'(m_bubbles == 0));
            check_val("fetch_pc", fetch_pc, m_fpc);
            check_val("state", 32'(state), (m_bubbles > 0) ? 32'd1 : (m_stalled ? 32'd2 : 32'd0));
            for (int i = 0; i < 3; i++)
                check_val($sformatf("pc%0d", i), pc[i], m_fpc + 32'(4 * i));
            if (m_bubbles == 0) begin
                check_val("lane_valid", 32'(fetch_lane_valid), 32'(m_lane_valid()));
                check_val("taken", 32'(fetch_taken), 32'(m_taken()));
                check_val("target", fetch_target, m_target());
            end
        end
    endtask

    task automatic advance();
        logic [31:0] tgt;
        tgt = m_target();
        @(posedge clk);
        if (rst) begin
            m_fpc = RESET_PC; m_bubbles = 0; m_stalled = 0;
        end else if (redirect_en) begin
            m_fpc = redirect_pc & ~32'h3; m_bubbles = FLUSH_BUBBLES; m_stalled = 0;
        end else if (m_bubbles > 0) begin
            m_bubbles--;
        end else if (fetch_ready) begin
            m_fpc = tgt; m_stalled = 0;
        end else begin
            m_stalled = 1;
        end
        #1;
    endtask

    task automatic drive(input logic [2:0] pv, input logic [2:0] pr, input logic ready,
                         input logic redir, input logic [31:0] rpc);
        predict_valid = pv;
        predict       = pr;
        fetch_ready   = ready;
        redirect_en   = redir;
        redirect_pc   = rpc;
    endtask

    task automatic go_to(input logic [31:0] target_pc);
        drive(3'b000, 3'b000, 1'b1, 1'b1, target_pc);
        sample(); advance();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0);
        sample(); check_val("bubble_valid", 32'(fetch_valid), 32'd0); advance();
    endtask

    initial begin
        rst = 1'b1;
        pc_predict = '0;
        drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0);
        #1;
        repeat (2) begin sample(); advance(); end
        rst = 1'b0;

        // Sequential fetch after reset
        sample(); check_val("seq0", fetch_pc, 32'h1c000000);
        check_val("seq_lane_valid", 32'(fetch_lane_valid), 32'b111);
        check_val("seq_taken", 32'(fetch_taken), 32'b000);
        advance();
        sample(); check_val("seq1", fetch_pc, 32'h1c00000c); advance();
        sample(); check_val("seq2", fetch_pc, 32'h1c000018); advance();

        // Lane 1 taken
        go_to(32'h1c000000);
        pc_predict[1] = 32'h1c000100;
        drive(3'b010, 3'b010, 1'b1, 1'b0, 32'h0);
        sample();
        check_val("l1_lane_valid", 32'(fetch_lane_valid), 32'b011);
        check_val("l1_taken", 32'(fetch_taken), 32'b010);
        check_val("l1_target", fetch_target, 32'h1c000100);
        advance();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0);
        sample(); check_val("l1_next", fetch_pc, 32'h1c000100); advance();

        // Lanes 0 and 2 taken: lane 0 wins
        pc_predict[0] = 32'h1c000200;
        pc_predict[2] = 32'h1c000300;
        drive(3'b101, 3'b101, 1'b1, 1'b0, 32'h0);
        sample();
        check_val("l02_lane_valid", 32'(fetch_lane_valid), 32'b001);
        check_val("l02_taken", 32'(fetch_taken), 32'b001);
        advance();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0);
        sample(); check_val("l02_next", fetch_pc, 32'h1c000200); advance();

        // Stall for three cycles, then release
        go_to(32'h1c00000c);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("hold_pc", fetch_pc, 32'h1c00000c);
            check_val("hold_valid", 32'(fetch_valid), 32'd1);
            if (i > 0) check_val("hold_state", 32'(state), 32'd2);
            advance();
        end
        fetch_ready = 1'b1;
        sample(); advance();
        sample(); check_val("hold_release", fetch_pc, 32'h1c000018);
        check_val("hold_release_state", 32'(state), 32'd0);
        advance();

        // Redirect during HOLD
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        sample(); advance();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h1c000043);
        sample(); advance();
        drive(3'b000, 3'b000, 1'b1, 1'b0, 32'h0);
        sample(); check_val("redir_valid", 32'(fetch_valid), 32'd0);
        check_val("redir_state", 32'(state), 32'd1);
        advance();
        sample(); check_val("redir_pc", fetch_pc, 32'h1c000040);
        check_val("redir_run", 32'(state), 32'd0);
        advance();

        // Wrap-around
        go_to(32'hfffffff4);
        sample(); advance();
        sample(); check_val("wrap", fetch_pc, 32'h00000000); advance();

        // Reset in HOLD
        fetch_ready = 1'b0;
        sample(); advance();
        sample(); advance();
        rst = 1'b1;
        sample(); advance();
        rst = 1'b0; fetch_ready = 1'b1;
        sample(); check_val("rst_hold", fetch_pc, 32'h1c000000);
        advance();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) pc_predict[i] = $urandom;
            predict_valid = 3'($urandom);
            predict       = 3'($urandom);
            fetch_ready   = ($urandom_range(0, 3) != 0);
            redirect_en   = ($urandom_range(0, 11) == 0);
            redirect_pc   = ($urandom_range(0, 3) == 0) ? (32'hffffffe0 | 32'($urandom_range(0, 31)))
                                                        : $urandom;
            rst           = ($urandom_range(0, 63) == 0);
            sample(); advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
